// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 rounding/packing pipe with valid/ready on both sides.
// Consumes the unrounded bundle from the FP arithmetic units and emits the final encoding and fflags.
package fp_pkg;
  typedef enum logic [1:0] {FP32 = 2'd0, FP16 = 2'd1, BF16 = 2'd2} fp_format_e;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} roundmode_e;

  function automatic int unsigned exp_bits(fp_format_e f);
    case (f)
      FP16:    return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e f);
    case (f)
      FP16:    return 10;
      BF16:    return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e f);
    return 1 + exp_bits(f) + man_bits(f);
  endfunction

  localparam int unsigned FLEN = fp_width(FP32);

  typedef struct packed {
    logic [FLEN-1:0] u_result;
    logic [1:0]      rs;
    logic            round_en;
    logic            invalid;
    logic [1:0]      exp_cout;
  } uround_res_t;
endpackage

module fp_round_pipe
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int unsigned FP_WIDTH   = fp_width(FP_FORMAT),
  localparam int unsigned EXP_WIDTH  = exp_bits(FP_FORMAT),
  localparam int unsigned MANT_WIDTH = man_bits(FP_FORMAT)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  uround_res_t         urnd_i,
  input  roundmode_e          rnd_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [FP_WIDTH-1:0] result_o,
  output logic [4:0]          fflags_o
);
  localparam int unsigned EMW    = EXP_WIDTH + MANT_WIDTH;
  localparam int unsigned STAGES = 2;

  logic [STAGES:1]     vld_pipe;
  uround_res_t         s1_urnd;
  roundmode_e          s1_rnd;
  logic [FP_WIDTH-1:0] s2_result;
  logic [4:0]          s2_flags;
  logic                adv1, fire_in, fire_out;

  assign adv1     = vld_pipe[1] & (~vld_pipe[2] | ready_i);
  assign ready_o  = ~vld_pipe[1] | adv1;
  assign fire_in  = valid_i & ready_o;
  assign fire_out = vld_pipe[2] & ready_i;

  // Rounding datapath, purely combinational from S1
  logic [FP_WIDTH-1:0]  u, of_word, rnd_word;
  logic [EMW-1:0]       em;
  logic [EMW:0]         sum;
  logic [EXP_WIDTH-1:0] exp_pre, exp_rnd;
  logic                 sign, g, s, inexact, inc, of, uf, nx, to_inf;
  logic [4:0]           flags;

  assign u       = s1_urnd.u_result[FP_WIDTH-1:0];
  assign sign    = u[FP_WIDTH-1];
  assign em      = u[EMW-1:0];
  assign exp_pre = u[EMW-1:MANT_WIDTH];
  assign g       = s1_urnd.rs[1];
  assign s       = s1_urnd.rs[0];
  assign inexact = g | s;

  always_comb begin
    inc    = 1'b0;
    to_inf = 1'b1;
    case (s1_rnd)
      RNE:     inc = g & (s | em[0]);
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & inexact;
      RUP:     inc = ~sign & inexact;
      RMM:     inc = g;
      default: inc = 1'b0;
    endcase
    if (!s1_urnd.round_en) inc = 1'b0;
    // Directed modes saturate to max finite when rounding away from the infinity's sign
    case (s1_rnd)
      RTZ:     to_inf = 1'b0;
      RDN:     to_inf = sign;
      RUP:     to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase
    sum     = {1'b0, em} + {{EMW{1'b0}}, inc};
    exp_rnd = sum[EMW-1:MANT_WIDTH];
    of      = s1_urnd.round_en & ((|s1_urnd.exp_cout) | sum[EMW] | (&exp_rnd));
    uf      = s1_urnd.round_en & ~(|exp_pre) & inexact;
    nx      = (s1_urnd.round_en & inexact) | of;
    of_word = to_inf ? {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}}
                     : {sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
    if (!s1_urnd.round_en) rnd_word = u;
    else if (of)           rnd_word = of_word;
    else                   rnd_word = {sign, sum[EMW-1:0]};
    flags = {s1_urnd.invalid, 1'b0, of, uf, nx};
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      vld_pipe  <= '0;
      s1_urnd   <= '0;
      s1_rnd    <= RNE;
      s2_result <= '0;
      s2_flags  <= '0;
    end else begin
      if (fire_in) begin
        vld_pipe[1] <= 1'b1;
        s1_urnd     <= urnd_i;
        s1_rnd      <= rnd_i;
      end else if (adv1) begin
        vld_pipe[1] <= 1'b0;
      end
      if (adv1) begin
        vld_pipe[2] <= 1'b1;
        s2_result   <= rnd_word;
        s2_flags    <= flags;
      end else if (fire_out) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

  assign valid_o  = vld_pipe[2];
  assign result_o = s2_result;
  assign fflags_o = s2_flags;
endmodule

// File: tb/tb_fp_round_pipe.sv
// Randomized + directed bench for fp_round_pipe against an arithmetic rounding model and expected-result queue.
module tb_fp_round_pipe;
  import fp_pkg::*;

  logic        clk_i = 1'b0, reset_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic        ready_o, valid_o;
  uround_res_t urnd_i = '0;
  roundmode_e  rnd_i = RNE;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  int n_vec = 0, n_err = 0;
  logic [36:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  fp_round_pipe #(.FP_FORMAT(FP32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .urnd_i(urnd_i), .rnd_i(rnd_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .fflags_o(fflags_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Result of rounding the magnitude as an integer, then saturating per mode on overflow
  function automatic logic [36:0] model(input uround_res_t b, input roundmode_e m);
    logic sign, g, s, inexact, up, of, uf, nx, to_inf;
    longint unsigned mag, mag_r, e0, e_r;
    logic [31:0] r;
    if (!b.round_en) return {b.invalid, 4'b0, b.u_result};
    sign    = b.u_result[31];
    mag     = {33'b0, b.u_result[30:0]};
    e0      = mag >> 23;
    g       = b.rs[1];
    s       = b.rs[0];
    inexact = g || s;
    case (m)
      RNE:     up = (g && s) || (g && !s && mag[0]);
      RTZ:     up = 1'b0;
      RDN:     up = sign && inexact;
      RUP:     up = !sign && inexact;
      default: up = g;
    endcase
    mag_r = mag + {63'b0, up};
    e_r   = mag_r >> 23;
    of    = (b.exp_cout != 2'b0) || (e_r >= 255);
    r     = {sign, mag_r[30:0]};
    if (of) begin
      to_inf = (m == RNE) || (m == RMM) || (m == RDN && sign) || (m == RUP && !sign);
      r = to_inf ? {sign, 31'h7F800000} : {sign, 31'h7F7FFFFF};
    end
    uf = (e0 == 0) && inexact;
    nx = inexact || of;
    return {b.invalid, 1'b0, of, uf, nx, r};
  endfunction

  always @(negedge clk_i) begin
    if (!reset_i) exp_q.delete();
    else begin
      check("ready_o", 64'(ready_o), 64'(!(exp_q.size() == 2 && !ready_i)));
      if (valid_o) begin
        if (exp_q.size() == 0) check("spurious_valid", 64'(valid_o), 64'd0);
        else begin
          check("result", 64'({fflags_o, result_o}), 64'(exp_q[0]));
          if (ready_i) void'(exp_q.pop_front());
        end
      end
      if (valid_i && ready_o) exp_q.push_back(model(urnd_i, rnd_i));
    end
  end

  task automatic drive(input logic [31:0] u, input logic [1:0] rs, input roundmode_e m,
                       input logic ren, input logic inv, input logic [1:0] ec);
    urnd_i.u_result = u; urnd_i.rs = rs; urnd_i.round_en = ren;
    urnd_i.invalid = inv; urnd_i.exp_cout = ec; rnd_i = m;
  endtask

  task automatic rand_drive();
    logic [7:0] e;
    logic [22:0] mt;
    case ($urandom_range(0, 3))
      0:       e = 8'd0;
      1:       e = 8'($urandom_range(253, 255));
      default: e = 8'($urandom);
    endcase
    mt = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
    drive({1'($urandom), e, mt}, 2'($urandom), roundmode_e'($urandom_range(0, 4)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b0);
  endtask

  task automatic directed(input string name, input logic [31:0] u, input logic [1:0] rs,
                          input roundmode_e m, input logic ren, input logic inv, input logic [1:0] ec,
                          input logic [31:0] er, input logic [4:0] ef);
    bit got;
    @(posedge clk_i); #1;
    ready_i = 1'b1; valid_i = 1'b1;
    drive(u, rs, m, ren, inv, ec);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk_i);
      if (valid_o) got = 1;
    end
    if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
    else check(name, 64'({fflags_o, result_o}), 64'({ef, er}));
  endtask

  initial begin
    bit saw_stall, adv;
    int sent;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_fflags", 64'(fflags_o), 64'd0);
    reset_i = 1'b1; #1;
    check("rst_ready", 64'(ready_o), 64'd1);

    directed("rne_tie_odd",  32'h3F800001, 2'b10, RNE, 1, 0, 2'b00, 32'h3F800002, 5'h01);
    directed("rne_tie_even", 32'h3F800000, 2'b10, RNE, 1, 0, 2'b00, 32'h3F800000, 5'h01);
    directed("of_rne",       32'h7F7FFFFF, 2'b11, RNE, 1, 0, 2'b01, 32'h7F800000, 5'h05);
    directed("of_rtz",       32'h7F7FFFFF, 2'b11, RTZ, 1, 0, 2'b01, 32'h7F7FFFFF, 5'h05);
    directed("of_rup_neg",   32'hFF7FFFFF, 2'b11, RUP, 1, 0, 2'b01, 32'hFF7FFFFF, 5'h05);
    directed("of_rdn_neg",   32'hFF7FFFFF, 2'b11, RDN, 1, 0, 2'b01, 32'hFF800000, 5'h05);
    directed("of_carry_rmm", 32'h7F7FFFFF, 2'b10, RMM, 1, 0, 2'b00, 32'h7F800000, 5'h05);
    directed("rdn_neg",      32'hBF800000, 2'b01, RDN, 1, 0, 2'b00, 32'hBF800001, 5'h01);
    directed("uf_tiny",      32'h00000001, 2'b01, RNE, 1, 0, 2'b00, 32'h00000001, 5'h03);
    directed("passthru_nv",  32'h7FC00000, 2'b11, RNE, 0, 1, 2'b11, 32'h7FC00000, 5'h10);

    // Backpressure: six back-to-back bundles, downstream stalls for cycles 3..6
    @(posedge clk_i); #1;
    sent = 0; saw_stall = 0; adv = 1;
    for (int c = 1; c <= 40 && sent < 6; c++) begin
      ready_i = !(c >= 3 && c <= 6);
      valid_i = 1'b1;
      if (adv) drive(32'h3F800000 | 32'(sent * 3), 2'($urandom), RNE, 1, 0, 2'b00);
      @(negedge clk_i);
      adv = ready_o;
      if (!ready_o) saw_stall = 1;
      if (ready_o) sent++;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    check("bp_ready_low", 64'(saw_stall), 64'd1);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk_i);
    #1;
    check("bp_drain", 64'(exp_q.size()), 64'd0);

    // Random traffic with random downstream stalls
    for (int c = 0; c < 600; c++) begin
      @(posedge clk_i); #1;
      valid_i = $urandom_range(0, 2) != 0;
      ready_i = $urandom_range(0, 3) != 0;
      rand_drive();
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0; ready_i = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk_i);
    #1;
    check("rand_drain", 64'(exp_q.size()), 64'd0);

    // Reset with two bundles in flight
    @(posedge clk_i); #1;
    valid_i = 1'b1; drive(32'h3F800001, 2'b11, RNE, 1, 0, 2'b00);
    @(posedge clk_i); #1;
    drive(32'h40000001, 2'b11, RUP, 1, 0, 2'b00);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    reset_i = 1'b0; #1;
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_fflags", 64'(fflags_o), 64'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b1; #1;
    check("midrst_ready", 64'(ready_o), 64'd1);
    check("midrst_novalid", 64'(valid_o), 64'd0);
    @(posedge clk_i); #1;
    valid_i = 1'b1; drive(32'h3F800001, 2'b10, RNE, 1, 0, 2'b00);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    check("post_rst_lat1", 64'(valid_o), 64'd0);
    @(posedge clk_i); #1;
    check("post_rst_valid", 64'(valid_o), 64'd1);
    check("post_rst_value", 64'({fflags_o, result_o}), 64'({5'h01, 32'h3F800002}));
    repeat (3) @(posedge clk_i);
    #1;
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
